// File: rtl/flop_stage_rr_arbiter_if.sv
// Handshake bundle between NUM_REQ requesters, the shared flop stage and its consumer.
// slave = arbiter side, master = requester/consumer side.
interface flop_stage_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic                           out_valid;
  logic [DATA_W-1:0]              out_data;
  logic [SRC_W-1:0]               out_src;
  logic                           out_ready;
  logic                           busy;

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, busy
  );

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/flop_stage_rr_arbiter.sv
// Round-robin arbiter feeding one registered pipeline stage; output fully registered.
// Optional per-requester grant counters enabled by RR_GRANT_COUNT_EN.
`ifdef RR_GRANT_COUNT_EN
module rr_grant_ctr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 16'd1;
  end
endmodule
`endif

module flop_stage_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
`ifdef RR_GRANT_COUNT_EN
  input  logic                        cnt_clr,
  output logic [NUM_REQ-1:0][15:0]    grant_cnt,
`endif
  flop_stage_rr_arbiter_if.slave      bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   win;
  logic               found;
  logic               can_load;
  logic               load;
  logic [NUM_REQ-1:0] grant_vec;

  // Rotating priority search starting at rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int j;
    logic [SRC_W-1:0] idx;
    found = 1'b0;
    win   = '0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = SRC_W'(j);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign can_load      = (state == EMPTY) | bus.out_ready;
  assign grant_vec     = found ? (NUM_REQ'(1) << win) : '0;
  assign bus.req_ready = (rst_n && can_load) ? grant_vec : '0;
  assign load          = |(bus.req_valid & bus.req_ready);
  assign bus.out_valid = (state == FULL);
  assign bus.busy      = bus.out_valid | (|bus.req_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= EMPTY;
      bus.out_data <= '0;
      bus.out_src  <= '0;
      rr_ptr       <= '0;
    end else begin
      case (state)
        EMPTY: if (load) state <= FULL;
        FULL:  if (bus.out_ready && !load) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      // A load in the drain cycle overwrites the departing payload: no bubble.
      if (load) begin
        bus.out_data <= bus.req_data[win];
        bus.out_src  <= win;
        rr_ptr       <= (win == SRC_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      end
    end
  end

`ifdef RR_GRANT_COUNT_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ctr
    rr_grant_ctr u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (bus.req_valid[i] & bus.req_ready[i]),
      .cnt   (grant_cnt[i])
    );
  end
`endif
endmodule

// File: tb/tb_flop_stage_rr_arbiter.sv
// Directed + randomized bench for flop_stage_rr_arbiter against a transaction-level model.
// Counter checks compile in when RR_GRANT_COUNT_EN is defined.
module tb_flop_stage_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flop_stage_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(SW)) bus ();

`ifdef RR_GRANT_COUNT_EN
  logic                cnt_clr;
  logic [N-1:0][15:0]  grant_cnt;
`endif

  flop_stage_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SRC_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef RR_GRANT_COUNT_EN
    .cnt_clr   (cnt_clr),
    .grant_cnt (grant_cnt),
`endif
    .bus       (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: holding register contents, pointer and grant tallies.
  int          m_ptr;
  bit          m_valid;
  logic [31:0] m_data;
  int          m_src;
  int          m_cnt [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner();
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Check grant side before the edge, advance the model on the edge, check outputs after.
  task automatic tick();
    int w;
    bit ld;
    logic [N-1:0] exp_rdy;
    w  = pick_winner();
    ld = rst_n && (!m_valid || bus.out_ready) && (w >= 0);
    exp_rdy = ld ? (N'(1) << w) : '0;
    #1;
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("busy", 64'(bus.busy), 64'(m_valid | (|bus.req_valid)));
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
`ifdef RR_GRANT_COUNT_EN
      if (cnt_clr) for (int i = 0; i < N; i++) m_cnt[i] = 0;
      else if (ld) m_cnt[w] = (m_cnt[w] + 1) % 65536;
`endif
      if (ld) begin
        m_data = bus.req_data[w]; m_src = w; m_valid = 1; m_ptr = (w + 1) % N;
      end else if (m_valid && bus.out_ready) m_valid = 0;
    end
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("out_data", 64'(bus.out_data), 64'(m_data));
    chk("out_src", 64'(bus.out_src), 64'(m_src));
`ifdef RR_GRANT_COUNT_EN
    for (int i = 0; i < N; i++) chk("grant_cnt", 64'(grant_cnt[i]), 64'(m_cnt[i]));
`endif
  endtask

  initial begin
    m_ptr = 0; m_valid = 0; m_data = '0; m_src = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    rst_n = 1'b0;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) bus.req_data[i] = 32'hA0 + 32'(i);
`ifdef RR_GRANT_COUNT_EN
    cnt_clr = 1'b0;
`endif
    @(negedge clk);

    // Reset held with every requester asking.
    bus.req_valid = 4'b1111;
    repeat (3) tick();
    chk("rst_out_data", 64'(bus.out_data), 64'h0);

    // Full contention, consumer always ready: 0,1,2,3,0 back to back.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rr_seq_src", 64'(bus.out_src), 64'(k % N));
      chk("rr_seq_valid", 64'(bus.out_valid), 64'h1);
    end

    // Stall while FULL with requester 2 held.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_src", 64'(bus.out_src), 64'h2);
      chk("stall_data", 64'(bus.out_data), 64'hA2);
    end
    bus.out_ready = 1'b1;
    bus.req_valid = 4'b1001;
    tick();
    chk("after_stall_src", 64'(bus.out_src), 64'h3);

    // Lone requester gets back-to-back grants; pointer then wraps past it.
    bus.req_valid = 4'b0010;
    repeat (4) begin
      tick();
      chk("lone_src", 64'(bus.out_src), 64'h1);
    end
    bus.req_valid = 4'b0011;
    tick();
    chk("wrap_src", 64'(bus.out_src), 64'h0);

    // Single load then drain: payload and source hold after out_valid drops.
    bus.req_valid = 4'b0100;
    bus.req_data[2] = 32'h55;
    tick();
    bus.req_valid = '0;
    tick();
    chk("drain_valid", 64'(bus.out_valid), 64'h0);
    chk("drain_data", 64'(bus.out_data), 64'h55);
    chk("drain_src", 64'(bus.out_src), 64'h2);
    tick();

`ifdef RR_GRANT_COUNT_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    bus.req_valid = 4'b0001; repeat (10) tick();
    bus.req_valid = 4'b0010; repeat (3) tick();
    bus.req_valid = '0; tick();
    chk("cnt0_10", 64'(grant_cnt[0]), 64'd10);
    chk("cnt1_3", 64'(grant_cnt[1]), 64'd3);
    cnt_clr = 1'b1; bus.req_valid = 4'b0001; tick();
    cnt_clr = 1'b0; bus.req_valid = '0;
    chk("clr_cnt0", 64'(grant_cnt[0]), 64'd0);
    chk("clr_cnt1", 64'(grant_cnt[1]), 64'd0);
`endif

    // Randomized traffic with occasional reset and consumer back-pressure.
    for (int c = 0; c < 600; c++) begin
      rst_n         = ($urandom_range(0, 60) != 0);
      bus.req_valid = N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) bus.req_data[i] = $urandom;
`ifdef RR_GRANT_COUNT_EN
      cnt_clr = ($urandom_range(0, 40) == 0);
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
